slot_demux_4: RTL and testbench

Four-slot registered demultiplexer: the write-side counterpart of the board-level 4:1 selector. It steers one WIDTH-bit character from the switch bank into one of four holding slots, addressed explicitly or by an auto-incrementing pointer. It sits between the switch/key input stage and the 4:1 selector/LED and HEX display logic, which read the flat slot bus.

---
 rtl/slot_demux_pkg.sv | 13 +
 rtl/slot_demux_4.sv | 105 ++++++++++
 tb/tb_slot_demux_4.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_demux_pkg.sv
// Shared types for the four-slot registered demultiplexer.
package slot_demux_pkg;

  localparam int NUM_SLOTS = 4;

  typedef logic [1:0] slot_idx_t;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

endpackage

// File: rtl/slot_demux_4.sv
// slot_demux_4: steers one character into one of four holding slots,
// addressed explicitly (in_sel) or by an auto-incrementing pointer, with a
// four-cycle clear sweep. Optional build macro OVERWRITE_FLAG_EN adds a
// sticky flag that records a write landing on an already-valid slot.
module slot_demux_4
  import slot_demux_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                   CLOCK_50,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH-1:0]       in_data,
  input  logic [1:0]             in_sel,
  input  logic                   auto_mode,
  input  logic                   clear,
  output logic [4*WIDTH-1:0]     slots,
  output logic [3:0]             slot_valid,
  output logic                   full,
  output logic [1:0]             wr_ptr,
  output logic                   ovr
);

  state_t           state_q;
  slot_idx_t        sweep_q;
  slot_idx_t        wr_ptr_q;
  logic [3:0]       slot_valid_q;
  logic [WIDTH-1:0] slots_q [NUM_SLOTS];

  slot_idx_t        tgt_d;
  logic             wr_en_d;

  // Handshake and write-target selection; clear pre-empts any same-cycle write.
  always_comb begin
    in_ready = (state_q == IDLE) && !clear && !reset;
    wr_en_d  = in_valid && in_ready;
    tgt_d    = auto_mode ? wr_ptr_q : in_sel;
  end

`ifdef OVERWRITE_FLAG_EN
  logic ovr_q;
`endif

  // All block state: slot storage, valid flags, pointer, sweep FSM.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      sweep_q      <= '0;
      wr_ptr_q     <= '0;
      slot_valid_q <= '0;
      for (int k = 0; k < NUM_SLOTS; k++) slots_q[k] <= '0;
`ifdef OVERWRITE_FLAG_EN
      ovr_q        <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (clear) begin
            state_q <= CLEAR;
            sweep_q <= '0;
          end else if (wr_en_d) begin
            slots_q[tgt_d]      <= in_data;
            slot_valid_q[tgt_d] <= 1'b1;
            if (auto_mode) wr_ptr_q <= wr_ptr_q + 2'd1;
`ifdef OVERWRITE_FLAG_EN
            if (slot_valid_q[tgt_d]) ovr_q <= 1'b1;
`endif
          end
        end
        CLEAR: begin
          slots_q[sweep_q]      <= '0;
          slot_valid_q[sweep_q] <= 1'b0;
          if (sweep_q == 2'd3) begin
            // Sweep finished: pointer and overwrite history start fresh.
            wr_ptr_q <= '0;
            state_q  <= IDLE;
`ifdef OVERWRITE_FLAG_EN
            ovr_q    <= 1'b0;
`endif
          end else begin
            sweep_q <= sweep_q + 2'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Flatten slot storage onto the bus read by the display logic.
  for (genvar k = 0; k < NUM_SLOTS; k++) begin : g_flat
    assign slots[k*WIDTH +: WIDTH] = slots_q[k];
  end

  assign slot_valid = slot_valid_q;
  assign full       = &slot_valid_q;
  assign wr_ptr     = wr_ptr_q;

`ifdef OVERWRITE_FLAG_EN
  assign ovr = ovr_q;
`else
  assign ovr = 1'b0;
`endif

endmodule

// File: tb/tb_slot_demux_4.sv
// Bench for slot_demux_4: directed vector table, hand-written clear/reset
// sequences and a randomized run against a behavioural model.
module tb_slot_demux_4;

`ifdef OVERWRITE_FLAG_EN
  localparam logic OVR_EN = 1'b1;
`else
  localparam logic OVR_EN = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic [1:0] in_sel;
  logic       auto_mode;
  logic       clear;
  logic [7:0] slots;
  logic [3:0] slot_valid;
  logic       full;
  logic [1:0] wr_ptr;
  logic       ovr;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  slot_demux_4 #(.WIDTH(2)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .auto_mode (auto_mode),
    .clear     (clear),
    .slots     (slots),
    .slot_valid(slot_valid),
    .full      (full),
    .wr_ptr    (wr_ptr),
    .ovr       (ovr)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  // Behavioural model: slot contents, flags, pointer, and sweep position
  // (-1 when idle, otherwise the next slot to be cleared).
  logic [1:0] m_slot [4];
  logic       m_val  [4];
  int         m_ptr;
  logic       m_ovr;
  int         m_sweep;

  task automatic m_reset();
    for (int k = 0; k < 4; k++) begin m_slot[k] = 2'd0; m_val[k] = 1'b0; end
    m_ptr = 0; m_ovr = 1'b0; m_sweep = -1;
  endtask

  task automatic m_step();
    int t;
    if (m_sweep < 0) begin
      if (clear) m_sweep = 0;
      else if (in_valid) begin
        t = auto_mode ? m_ptr : int'(in_sel);
        if (OVR_EN && m_val[t]) m_ovr = 1'b1;
        m_slot[t] = in_data;
        m_val[t]  = 1'b1;
        if (auto_mode) m_ptr = (m_ptr + 1) % 4;
      end
    end else begin
      m_slot[m_sweep] = 2'd0;
      m_val[m_sweep]  = 1'b0;
      m_sweep++;
      if (m_sweep == 4) begin m_sweep = -1; m_ptr = 0; m_ovr = 1'b0; end
    end
  endtask

  function automatic logic [16:0] m_out();
    logic [7:0] s;
    logic [3:0] v;
    for (int k = 0; k < 4; k++) begin s[k*2 +: 2] = m_slot[k]; v[k] = m_val[k]; end
    return {s, v, &v, m_ptr[1:0], m_ovr, (m_sweep < 0) && !clear && !reset};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    if (reset) m_reset(); else m_step();
    @(posedge CLOCK_50);
    #1;
    chk("model", {15'd0, slots, slot_valid, full, wr_ptr, ovr, in_ready}, {15'd0, m_out()});
  endtask

  typedef struct {
    logic       auto_m;
    logic [1:0] sel;
    logic [1:0] data;
    logic [7:0] e_slots;
    logic [3:0] e_valid;
    logic       e_full;
    logic [1:0] e_ptr;
    logic       e_ovr;
  } vec_t;

  vec_t tbl [11];

  task automatic apply_vec(input int i);
    in_valid  = 1'b1;
    auto_mode = tbl[i].auto_m;
    in_sel    = tbl[i].sel;
    in_data   = tbl[i].data;
    tick();
    in_valid = 1'b0;
    chk($sformatf("vec%0d slots", i), slots, tbl[i].e_slots);
    chk($sformatf("vec%0d valid", i), slot_valid, tbl[i].e_valid);
    chk($sformatf("vec%0d full", i), full, tbl[i].e_full);
    chk($sformatf("vec%0d ptr", i), wr_ptr, tbl[i].e_ptr);
    chk($sformatf("vec%0d ovr", i), ovr, tbl[i].e_ovr);
  endtask

  initial begin
    tbl[0]  = '{1'b0, 2'd0, 2'd1, 8'b00_00_00_01, 4'b0001, 1'b0, 2'd0, 1'b0};
    tbl[1]  = '{1'b0, 2'd1, 2'd2, 8'b00_00_10_01, 4'b0011, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{1'b0, 2'd2, 2'd3, 8'b00_11_10_01, 4'b0111, 1'b0, 2'd0, 1'b0};
    tbl[3]  = '{1'b0, 2'd3, 2'd0, 8'b00_11_10_01, 4'b1111, 1'b1, 2'd0, 1'b0};
    tbl[4]  = '{1'b1, 2'd3, 2'd3, 8'b00_00_00_11, 4'b0001, 1'b0, 2'd1, 1'b0};
    tbl[5]  = '{1'b1, 2'd0, 2'd2, 8'b00_00_10_11, 4'b0011, 1'b0, 2'd2, 1'b0};
    tbl[6]  = '{1'b1, 2'd1, 2'd1, 8'b00_01_10_11, 4'b0111, 1'b0, 2'd3, 1'b0};
    tbl[7]  = '{1'b1, 2'd2, 2'd0, 8'b00_01_10_11, 4'b1111, 1'b1, 2'd0, 1'b0};
    tbl[8]  = '{1'b1, 2'd2, 2'd1, 8'b00_01_10_01, 4'b1111, 1'b1, 2'd1, OVR_EN};
    tbl[9]  = '{1'b0, 2'd2, 2'd3, 8'b00_11_10_01, 4'b1111, 1'b1, 2'd1, OVR_EN};
    tbl[10] = '{1'b1, 2'd3, 2'd0, 8'b00_11_00_01, 4'b1111, 1'b1, 2'd2, OVR_EN};

    reset = 1'b1; in_valid = 1'b0; in_data = 2'd0; in_sel = 2'd0;
    auto_mode = 1'b0; clear = 1'b0;
    m_reset();
    tick(); tick();
    chk("reset slots", slots, 8'd0);
    chk("reset valid", slot_valid, 4'd0);
    chk("reset full", full, 1'b0);
    chk("reset ptr", wr_ptr, 2'd0);
    chk("reset ovr", ovr, 1'b0);
    chk("reset ready", in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("ready after reset", in_ready, 1'b1);

    // Explicit writes fill all four slots.
    for (int i = 0; i < 4; i++) apply_vec(i);

    // Clear together with a write request: no write, then ordered sweep.
    clear = 1'b1; in_valid = 1'b1; in_sel = 2'd0; in_data = 2'd3; auto_mode = 1'b0;
    #1;
    chk("clr ready0", in_ready, 1'b0);
    tick();
    chk("clr nowrite", slots, 8'b00_11_10_01);
    clear = 1'b0; in_valid = 1'b0;
    tick();
    chk("sweep1 slots", slots, 8'b00_11_10_00);
    chk("sweep1 valid", slot_valid, 4'b1110);
    chk("sweep1 ready", in_ready, 1'b0);
    tick();
    chk("sweep2 slots", slots, 8'b00_11_00_00);
    chk("sweep2 ready", in_ready, 1'b0);
    tick();
    chk("sweep3 slots", slots, 8'b00_00_00_00);
    chk("sweep3 valid", slot_valid, 4'b1000);
    chk("sweep3 ready", in_ready, 1'b0);
    tick();
    chk("sweep4 valid", slot_valid, 4'b0000);
    chk("sweep4 ptr", wr_ptr, 2'd0);
    chk("sweep4 ready", in_ready, 1'b1);

    // Auto writes with wrap, then explicit write leaves pointer alone.
    for (int i = 4; i < 11; i++) apply_vec(i);

    // clear held for 10 cycles: two back-to-back sweeps, no writes.
    clear = 1'b1; in_valid = 1'b1; auto_mode = 1'b1; in_data = 2'd3;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk($sformatf("hold%0d ready", c), in_ready, 1'b0);
    end
    chk("hold slots", slots, 8'd0);
    chk("hold valid", slot_valid, 4'd0);
    clear = 1'b0; in_valid = 1'b0;
    #1;
    chk("hold end ready", in_ready, 1'b1);

    // clear held 6 cycles: second sweep runs on after clear drops.
    clear = 1'b1;
    for (int c = 0; c < 6; c++) tick();
    clear = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk($sformatf("tail%0d ready", c), in_ready, 1'b0);
    end
    tick();
    chk("tail end ready", in_ready, 1'b1);

    // Reset in the middle of a sweep with slots 2 and 3 still loaded.
    in_valid = 1'b1; auto_mode = 1'b0;
    in_sel = 2'd2; in_data = 2'd2; tick();
    in_sel = 2'd3; in_data = 2'd3; tick();
    in_valid = 1'b0;
    chk("pre-abort slots", slots, 8'b11_10_00_00);
    clear = 1'b1; tick();
    clear = 1'b0; tick(); tick();
    chk("mid-sweep slot3", slots[7:6], 2'd3);
    reset = 1'b1;
    #1;
    chk("abort slots", slots, 8'd0);
    chk("abort valid", slot_valid, 4'd0);
    chk("abort ptr", wr_ptr, 2'd0);
    chk("abort ready", in_ready, 1'b0);
    chk("abort full", full, 1'b0);
    tick();
    reset = 1'b0;
    #1;
    chk("abort idle ready", in_ready, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 500; n++) begin
      clear     = ($urandom_range(0, 15) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      auto_mode = $urandom_range(0, 1) == 1;
      in_sel    = 2'($urandom_range(0, 3));
      in_data   = 2'($urandom_range(0, 3));
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
